// File: rtl/filter_history_writer.sv
// Shifts the per-slot sample history (bank0 <- x[n], bank1 <- bank0, bank2 <- bank1)
// through one shared write port, with a zero-fill sweep after reset or on request.
module filter_history_writer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic                            i_Clear,
  input  logic                            i_SampleValid,
  input  logic        [ADDRESS_WIDTH-1:0] i_SampleAddress,
  input  logic signed [DATA_WIDTH-1:0]    i_SampleData,
  output logic                            o_SampleReady,
  output logic        [ADDRESS_WIDTH-1:0] o_HistoryReadAddress,
  input  logic signed [DATA_WIDTH-1:0]    i_HistoryReadData [3],
  output logic                            o_WriteEnable,
  output logic        [ADDRESS_WIDTH-1:0] o_WriteAddress,
  output logic signed [DATA_WIDTH-1:0]    o_WriteData [3],
  output logic                            o_Busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state_q, state_d;
  logic   [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  logic                            s1_valid_q, s1_valid_d;
  logic        [ADDRESS_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic signed [DATA_WIDTH-1:0]    s1_data_q, s1_data_d;
  logic                            s1_fwd_q, s1_fwd_d;
  logic signed [DATA_WIDTH-1:0]    s1_fwd0_q, s1_fwd0_d;
  logic signed [DATA_WIDTH-1:0]    s1_fwd1_q, s1_fwd1_d;

  logic                            we_q;
  logic        [ADDRESS_WIDTH-1:0] waddr_q;
  logic signed [DATA_WIDTH-1:0]    wdata_q [3];
  logic signed [DATA_WIDTH-1:0]    wdata_d [3];

  logic accept;
  logic unused_bank2;

  // Bank2's old value is shifted out and never needed.
  assign unused_bank2 = ^i_HistoryReadData[2];

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (i_Clear) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDRESS_WIDTH'(1);
        end
      end
      RUN: begin
        if (i_Clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_SampleReady = (state_q == RUN);
    o_Busy        = (state_q == CLEAR);
  end

  assign accept               = (state_q == RUN) && i_SampleValid;
  assign o_HistoryReadAddress = i_SampleAddress;

  always_comb begin
    wdata_d[0] = s1_data_q;
    wdata_d[1] = s1_fwd_q ? s1_fwd0_q : i_HistoryReadData[0];
    wdata_d[2] = s1_fwd_q ? s1_fwd1_q : i_HistoryReadData[1];
  end

  // Sweep entries ride the same stage-1 slot as samples, so a sample accepted with
  // i_Clear still gets the first write slot and the sweep follows one cycle behind.
  // Forwarding is decided at accept time: the two younger entries (stage 1, write
  // register) are not yet visible in the registered read-back.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    s1_fwd_d   = s1_fwd_q;
    s1_fwd0_d  = s1_fwd0_q;
    s1_fwd1_d  = s1_fwd1_q;
    if (state_q == CLEAR) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = cnt_q;
      s1_data_d  = '0;
      s1_fwd_d   = 1'b1;
      s1_fwd0_d  = '0;
      s1_fwd1_d  = '0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = i_SampleAddress;
      s1_data_d  = i_SampleData;
      if (s1_valid_q && (s1_addr_q == i_SampleAddress)) begin
        s1_fwd_d  = 1'b1;
        s1_fwd0_d = wdata_d[0];
        s1_fwd1_d = wdata_d[1];
      end else if (we_q && (waddr_q == i_SampleAddress)) begin
        s1_fwd_d  = 1'b1;
        s1_fwd0_d = wdata_q[0];
        s1_fwd1_d = wdata_q[1];
      end else begin
        s1_fwd_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_fwd_q   <= 1'b0;
      s1_fwd0_q  <= '0;
      s1_fwd1_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '{default: '0};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_fwd_q   <= s1_fwd_d;
      s1_fwd0_q  <= s1_fwd0_d;
      s1_fwd1_q  <= s1_fwd1_d;
      we_q       <= s1_valid_q;
      if (s1_valid_q) begin
        waddr_q <= s1_addr_q;
        wdata_q <= wdata_d;
      end
    end
  end

  assign o_WriteEnable  = we_q;
  assign o_WriteAddress = waddr_q;
  assign o_WriteData    = wdata_q;

endmodule

// File: tb/tb_filter_history_writer.sv
// Scoreboard bench: a per-slot history model predicts every write; a BRAM model
// with registered read-old-during-write read-back closes the loop.
module tb_filter_history_writer;

  logic               clk;
  logic               i_Reset;
  logic               i_Clear;
  logic               i_SampleValid;
  logic        [7:0]  i_SampleAddress;
  logic signed [15:0] i_SampleData;
  logic               o_SampleReady;
  logic        [7:0]  o_HistoryReadAddress;
  logic signed [15:0] rd_data [3];
  logic               o_WriteEnable;
  logic        [7:0]  o_WriteAddress;
  logic signed [15:0] o_WriteData [3];
  logic               o_Busy;

  filter_history_writer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16)) dut (
    .i_Clock              (clk),
    .i_Reset              (i_Reset),
    .i_Clear              (i_Clear),
    .i_SampleValid        (i_SampleValid),
    .i_SampleAddress      (i_SampleAddress),
    .i_SampleData         (i_SampleData),
    .o_SampleReady        (o_SampleReady),
    .o_HistoryReadAddress (o_HistoryReadAddress),
    .i_HistoryReadData    (rd_data),
    .o_WriteEnable        (o_WriteEnable),
    .o_WriteAddress       (o_WriteAddress),
    .o_WriteData          (o_WriteData),
    .o_Busy               (o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] mem [3][256];

  initial begin
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = 16'($urandom);
  end

  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      rd_data[b] <= mem[b][o_HistoryReadAddress];
      if (o_WriteEnable) mem[b][o_WriteAddress] <= o_WriteData[b];
    end
  end

  typedef struct {
    logic        [7:0]  a;
    logic signed [15:0] d0, d1, d2;
  } wr_t;

  wr_t                exp_q [$];
  logic signed [15:0] ref_h [3][256];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_sweep();
    wr_t w;
    for (int a = 0; a < 256; a++) begin
      w.a = 8'(a); w.d0 = '0; w.d1 = '0; w.d2 = '0;
      exp_q.push_back(w);
      for (int b = 0; b < 3; b++) ref_h[b][a] = '0;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!i_Reset && o_WriteEnable) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0d data {%0d,%0d,%0d}, none expected",
                 o_WriteAddress, o_WriteData[0], o_WriteData[1], o_WriteData[2]);
      end else begin
        e = exp_q.pop_front();
        if (o_WriteAddress !== e.a || o_WriteData[0] !== e.d0 ||
            o_WriteData[1] !== e.d1 || o_WriteData[2] !== e.d2) begin
          fails++;
          $display("FAIL write: got addr %0d {%0d,%0d,%0d} expected addr %0d {%0d,%0d,%0d}",
                   o_WriteAddress, o_WriteData[0], o_WriteData[1], o_WriteData[2],
                   e.a, e.d0, e.d1, e.d2);
        end
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input bit v, input logic [7:0] a, input logic signed [15:0] d,
                       input bit clr);
    wr_t w;
    i_SampleValid   = v;
    i_SampleAddress = a;
    i_SampleData    = d;
    i_Clear         = clr;
    if (o_SampleReady && v) begin
      w.a = a; w.d0 = d; w.d1 = ref_h[0][a]; w.d2 = ref_h[1][a];
      exp_q.push_back(w);
      ref_h[2][a] = ref_h[1][a];
      ref_h[1][a] = ref_h[0][a];
      ref_h[0][a] = d;
    end
    if (o_SampleReady && clr) expect_sweep();
    @(negedge clk);
    i_SampleValid = 1'b0;
    i_Clear       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 16'sd0, 1'b0);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (o_Busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'd256);
    check({name, "_ready"}, 64'(o_SampleReady), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(o_WriteEnable), 64'd0);
    check({tag, "_busy"},  64'(o_Busy), 64'd1);
    check({tag, "_ready"}, 64'(o_SampleReady), 64'd0);
    check({tag, "_waddr"}, 64'(o_WriteAddress), 64'd0);
    check({tag, "_wdata"}, {16'd0, 16'(o_WriteData[0]), 16'(o_WriteData[1]),
                            16'(o_WriteData[2])}, 64'd0);
  endtask

  initial begin
    int ready_low;
    int bad;
    i_Reset = 1'b0; i_Clear = 1'b0; i_SampleValid = 1'b0;
    i_SampleAddress = '0; i_SampleData = '0;
    #1 i_Reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    expect_sweep();
    i_Reset = 1'b0;
    count_busy("busy_after_reset");
    drain();

    drive(1'b1, 8'd5, 16'sd100, 1'b0); idle(3);
    drive(1'b1, 8'd5, 16'sd200, 1'b0); idle(3);
    drive(1'b1, 8'd5, 16'sd300, 1'b0); idle(3);

    drive(1'b1, 8'd7, 16'sd2, 1'b0);   idle(3);
    drive(1'b1, 8'd7, 16'sd1, 1'b0);   idle(3);
    drive(1'b1, 8'd7, -16'sd5, 1'b0);
    drive(1'b1, 8'd7, 16'sd9, 1'b0);   idle(3);

    drive(1'b1, 8'd7, 16'sd11, 1'b0);  idle(1);
    drive(1'b1, 8'd7, 16'sd12, 1'b0);  idle(3);

    for (int i = 0; i < 8; i++)
      drive(1'b1, (i % 2 == 0) ? 8'd3 : 8'd4, 16'(i * 37 - 100), 1'b0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic signed [15:0] d;
      case ($urandom_range(0, 7))
        0:       d = 16'sh7FFF;
        1:       d = -16'sh8000;
        default: d = 16'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 5)), d, 1'b0);
    end
    idle(4);
    drain();
    idle(2);
    bad = 0;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 3; b++)
        if (mem[b][a] !== ref_h[b][a]) bad++;
    check("mem_image_after_random", 64'(bad), 64'd0);

    drive(1'b1, 8'd10, 16'sh7FFF, 1'b1);
    ready_low = 0;
    while (!o_SampleReady && ready_low < 1000) begin
      ready_low++;
      @(negedge clk);
    end
    check("ready_low_after_clear", 64'(ready_low), 64'd256);
    drain();
    idle(2);
    bad = 0;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 3; b++)
        if (mem[b][a] !== 16'sd0) bad++;
    check("mem_zero_after_clear", 64'(bad), 64'd0);

    drive(1'b1, 8'd10, 16'sd42, 1'b0);
    idle(3);
    drain();

    i_Reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    i_Reset = 1'b0;
    expect_sweep();
    repeat (128) @(negedge clk);
    #2 i_Reset = 1'b1;
    #1 check_reset_outputs("midsweep_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    expect_sweep();
    i_Reset = 1'b0;
    count_busy("busy_after_midsweep_reset");
    drain();
    idle(2);
    bad = 0;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 3; b++)
        if (mem[b][a] !== 16'sd0) bad++;
    check("mem_zero_after_midsweep_reset", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
